// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: display reads own tick-low cycles in active video; host and fill use every other cycle.
// Latency: RAM read data one cycle after issue; rgb_o trails the scan position by one pixel clock.
module vram_arbiter #(
    parameter int FB_W = 160,
    parameter int FB_H = 120,
    parameter int CW   = 3,
    parameter int AW   = 15
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          pixel_tick_i,
    input  logic [9:0]    pixel_x_i,
    input  logic [9:0]    pixel_y_i,
    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [CW-1:0] host_wdata_i,
    output logic          host_ack_o,
    output logic [CW-1:0] host_rdata_o,
    output logic          host_rvalid_o,
    input  logic          clr_i,
    input  logic [CW-1:0] clr_color_i,
    output logic          busy_o,
    output logic [AW-1:0] ram_addr_o,
    output logic          ram_we_o,
    output logic [CW-1:0] ram_wdata_o,
    input  logic [CW-1:0] ram_rdata_i,
    output logic [CW-1:0] rgb_o
);

    localparam int            FB_N      = FB_W * FB_H;
    localparam logic [AW:0]   FB_N_W    = (AW+1)'(FB_N);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FB_N - 1);
    localparam logic [31:0]   FB_W_BITS = 32'(FB_W);

    typedef enum logic {IDLE, FILL} state_t;

    state_t        state_q, state_d;
    logic          video_on, disp_slot, disp_q;
    logic          ack_q, rd_q, rd_oob_q;
    logic          host_issue, host_in_range, fill_wr;
    logic [AW-1:0] disp_addr, fill_cnt;
    logic [CW-1:0] fill_color;

    // Row-times-width as a sum of shifted copies, one adder per set bit of FB_W.
    function automatic logic [AW-1:0] times_fb_w(input logic [AW-1:0] v);
        logic [AW-1:0] acc;
        acc = '0;
        for (int i = 0; i < AW; i++) begin
            if (FB_W_BITS[i]) acc = acc + (v << i);
        end
        return acc;
    endfunction

    assign video_on      = (pixel_x_i < 10'd640) && (pixel_y_i < 10'd480);
    assign disp_slot     = video_on && !pixel_tick_i;
    assign disp_addr     = times_fb_w(AW'(pixel_y_i[9:2])) + AW'(pixel_x_i[9:2]);
    assign host_in_range = {1'b0, host_addr_i} < FB_N_W;

    always_comb begin
        state_d     = state_q;
        host_issue  = 1'b0;
        fill_wr     = 1'b0;
        ram_addr_o  = disp_addr;
        ram_we_o    = 1'b0;
        ram_wdata_o = host_wdata_i;
        case (state_q)
            IDLE: begin
                if (clr_i) begin
                    state_d = FILL;
                end else if (!disp_slot && host_req_i && !ack_q && !reset_i) begin
                    // ack_q blocks re-issuing a request the host has not yet dropped
                    host_issue = 1'b1;
                    ram_addr_o = host_addr_i;
                    ram_we_o   = host_we_i && host_in_range;
                end
            end
            FILL: begin
                if (!disp_slot) begin
                    fill_wr     = 1'b1;
                    ram_addr_o  = fill_cnt;
                    ram_we_o    = 1'b1;
                    ram_wdata_o = fill_color;
                    if (fill_cnt == LAST_ADDR) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign host_ack_o    = host_issue;
    assign busy_o        = (state_q == FILL);
    assign host_rvalid_o = rd_q;
    assign host_rdata_o  = (rd_q && !rd_oob_q) ? ram_rdata_i : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            fill_cnt   <= '0;
            fill_color <= '0;
            ack_q      <= 1'b0;
            rd_q       <= 1'b0;
            rd_oob_q   <= 1'b0;
            disp_q     <= 1'b0;
            rgb_o      <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= host_issue;
            rd_q     <= host_issue && !host_we_i;
            rd_oob_q <= !host_in_range;
            disp_q   <= disp_slot;
            if (state_q == IDLE && clr_i) begin
                fill_cnt   <= '0;
                fill_color <= clr_color_i;
            end else if (fill_wr) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            // Load edge ends each tick-high cycle; a non-display preceding slot blanks the pixel.
            if (pixel_tick_i) rgb_o <= disp_q ? ram_rdata_i : '0;
        end
    end

endmodule
